// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU for the execute stage (RV32I/RV64I OP and OP-IMM).
// Define MIMA_ALU_MDU_EN to add the iterative M-extension multiply/divide unit,
// which holds the stage in BUSY for XLEN cycles per operation.
//
// state | meaning
// IDLE  | ready for a new operation (in_ready high)
// BUSY  | iterative multiply/divide in progress, input ignored
// DONE  | result held on t/illegal until out_ready
module alu_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            op,
   input  logic            op_imm,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] t,
   output logic            illegal
);
   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nxt;
   logic            accept, legal, m_op;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] res_base;

   assign shamt  = b[SHW-1:0];
   assign accept = in_valid && (state == IDLE);

`ifdef MIMA_ALU_MDU_EN
   localparam int CW = $clog2(XLEN);

   logic [CW-1:0]     cnt;
   logic [2:0]        f3_q;
   logic              neg_q, zdiv_q, a_neg, b_neg, neg_in;
   logic [XLEN-1:0]   acc_hi, acc_lo, opnd, a_q, mag_a, mag_b;
   logic [XLEN-1:0]   iter_hi, iter_lo, q_s, r_s, mdu_res;
   logic [XLEN:0]     shifted, diff, sum;
   logic [2*XLEN-1:0] prod_raw, prod;
`endif

   // Decode legality and compute the single-cycle base result from live inputs
   always_comb begin
      legal    = 1'b0;
      m_op     = 1'b0;
      res_base = '0;
      if (op) begin
         if (funct7 == 7'b0000000)
            legal = 1'b1;
         else if (funct7 == 7'b0100000)
            legal = (funct3 == 3'b000) || (funct3 == 3'b101);
`ifdef MIMA_ALU_MDU_EN
         else if (funct7 == 7'b0000001)
            m_op = 1'b1;
`endif
      end else if (op_imm) begin
         case (funct3)
            3'b001:  legal = (funct7 == 7'b0000000);
            3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            default: legal = 1'b1;
         endcase
      end
      case (funct3)
         3'b000:  res_base = (op && funct7 == 7'b0100000) ? a - b : a + b;
         3'b001:  res_base = a << shamt;
         3'b010:  res_base = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         3'b011:  res_base = {{(XLEN-1){1'b0}}, a < b};
         3'b100:  res_base = a ^ b;
         3'b101:  res_base = (funct7 == 7'b0100000) ? $unsigned($signed(a) >>> shamt) : a >> shamt;
         3'b110:  res_base = a | b;
         default: res_base = a & b;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = m_op ? BUSY : DONE;
         end
`ifdef MIMA_ALU_MDU_EN
         BUSY: begin
            if (cnt == '0)
               state_nxt = DONE;
         end
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result register: base/illegal ops at accept, M ops on the final iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t       <= '0;
         illegal <= 1'b0;
      end else if (accept && !m_op) begin
         t       <= legal ? res_base : '0;
         illegal <= !legal;
      end
`ifdef MIMA_ALU_MDU_EN
      else if (state == BUSY && cnt == '0) begin
         t       <= mdu_res;
         illegal <= 1'b0;
      end
`endif
   end

`ifdef MIMA_ALU_MDU_EN
   // Operand magnitudes and result sign; MUL treats both operands as signed
   // since the low half of the product does not depend on signedness
   always_comb begin
      a_neg  = a[XLEN-1] && !(funct3 inside {3'b011, 3'b101, 3'b111});
      b_neg  = b[XLEN-1] && (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
      mag_a  = a_neg ? -a : a;
      mag_b  = b_neg ? -b : b;
      neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
   end

   // One iteration: shift-add multiply (hi:lo = product) or restoring divide (hi = rem, lo = quotient)
   always_comb begin
      shifted = {acc_hi, acc_lo[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      if (f3_q[2]) begin
         if (!diff[XLEN]) begin
            iter_hi = diff[XLEN-1:0];
            iter_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            iter_hi = shifted[XLEN-1:0];
            iter_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         iter_hi = sum[XLEN:1];
         iter_lo = {sum[0], acc_lo[XLEN-1:1]};
      end
   end

   // Sign fix-up and divide-by-zero override applied to the last iteration's output
   always_comb begin
      prod_raw = {iter_hi, iter_lo};
      prod     = neg_q ? -prod_raw : prod_raw;
      q_s      = neg_q ? -iter_lo : iter_lo;
      r_s      = neg_q ? -iter_hi : iter_hi;
      if (!f3_q[2])
         mdu_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if (zdiv_q)
         mdu_res = f3_q[1] ? a_q : '1;
      else
         mdu_res = f3_q[1] ? r_s : q_s;
   end

   // Iteration registers; cnt is a down-counter whose terminal count marks the last iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         f3_q   <= '0;
         neg_q  <= 1'b0;
         zdiv_q <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         a_q    <= '0;
      end else if (accept && m_op) begin
         cnt    <= CW'(XLEN - 1);
         f3_q   <= funct3;
         neg_q  <= neg_in;
         zdiv_q <= (b == '0);
         acc_hi <= '0;
         acc_lo <= funct3[2] ? mag_a : mag_b;
         opnd   <= funct3[2] ? mag_b : mag_a;
         a_q    <= a;
      end else if (state == BUSY) begin
         acc_hi <= iter_hi;
         acc_lo <= iter_lo;
         if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (XLEN=32): directed vector table, handshake/reset sequences,
// and random operations compared against an arithmetic reference model.
module tb_alu_seq;
   localparam int XLEN = 32;
`ifdef MIMA_ALU_MDU_EN
   localparam bit MDU = 1'b1;
`else
   localparam bit MDU = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, op, op_imm, out_valid, out_ready, illegal;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] a, b, t;
   int          checks = 0;
   int          errors = 0;

   alu_seq #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .op_imm(op_imm), .funct3(funct3), .funct7(funct7),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .t(t), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      string     name;
      bit        o, oi;
      bit [2:0]  f3;
      bit [6:0]  f7;
      bit [31:0] av, bv, et;
      bit        ei;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout waiting on handshake", name);
   endtask

   function automatic void add_vec(input string n, input bit o, input bit oi, input bit [2:0] f3,
                                   input bit [6:0] f7, input bit [31:0] av, input bit [31:0] bv,
                                   input bit [31:0] et, input bit ei);
      vecs.push_back('{n, o, oi, f3, f7, av, bv, et, ei});
   endfunction

   // Reference model: ISA semantics with plain integer arithmetic
   function automatic void model(input bit o, input bit oi, input bit [2:0] f3, input bit [6:0] f7,
                                 input bit [31:0] av, input bit [31:0] bv,
                                 output bit [31:0] et, output bit ei, output int lat);
      bit [4:0]          sh = bv[4:0];
      int                sa = av;
      int                sb = bv;
      longint            sa64 = sa;
      longint            sb64 = sb;
      longint            ub64 = {32'b0, bv};
      longint unsigned   ua_u = {32'b0, av};
      longint unsigned   ub_u = {32'b0, bv};
      longint            p;
      longint unsigned   p_u;
      bit                ovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
      et  = '0;
      ei  = 1'b1;
      lat = 1;
      if (o) begin
         if (f7 == 7'h01) begin
            if (!MDU) return;
            ei  = 1'b0;
            lat = XLEN + 1;
            case (f3)
               3'd0: begin p = sa64 * sb64; et = p[31:0]; end
               3'd1: begin p = sa64 * sb64; et = p[63:32]; end
               3'd2: begin p = sa64 * ub64; et = p[63:32]; end
               3'd3: begin p_u = ua_u * ub_u; et = p_u[63:32]; end
               3'd4: if (bv == 0) et = '1; else if (ovf) et = av; else et = 32'(sa / sb);
               3'd5: if (bv == 0) et = '1; else et = av / bv;
               3'd6: if (bv == 0) et = av; else if (ovf) et = '0; else et = 32'(sa % sb);
               default: if (bv == 0) et = av; else et = av % bv;
            endcase
            return;
         end
         if (f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) return;
      end else if (oi) begin
         if (f3 == 3'd1 && f7 != 7'h00) return;
         if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return;
      end else begin
         return;
      end
      ei = 1'b0;
      case (f3)
         3'd0: et = (o && f7 == 7'h20) ? av - bv : av + bv;
         3'd1: et = av << sh;
         3'd2: et = (sa < sb) ? 32'd1 : 32'd0;
         3'd3: et = (av < bv) ? 32'd1 : 32'd0;
         3'd4: et = av ^ bv;
         3'd5: et = (f7 == 7'h20) ? 32'(sa >>> sh) : av >> sh;
         3'd6: et = av | bv;
         default: et = av & bv;
      endcase
   endfunction

   // Present one op, measure cycles to out_valid, check result, then consume it
   task automatic run_op(input string name, input bit o, input bit oi, input bit [2:0] f3,
                         input bit [6:0] f7, input bit [31:0] av, input bit [31:0] bv,
                         input bit [31:0] et, input bit ei, input int elat);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         timeout({name, "_accept"});
         return;
      end
      op = o; op_imm = oi; funct3 = f3; funct7 = f7; a = av; b = bv; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 1'($urandom); op_imm = 1'($urandom); funct3 = 3'($urandom);
      funct7 = 7'($urandom); a = $urandom; b = $urandom;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      if (!out_valid) begin
         timeout({name, "_result"});
         return;
      end
      chk({name, "_latency"}, 32'(n), 32'(elat));
      chk({name, "_t"}, t, et);
      chk({name, "_illegal"}, {31'b0, illegal}, {31'b0, ei});
      chk({name, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   function automatic bit [31:0] pick32();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit [31:0] et;
      bit        ei;
      int        lat;
      bit        o, oi;
      bit [2:0]  f3;
      bit [6:0]  f7;
      bit [31:0] av, bv;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; op_imm = 1'b0;
      funct3 = '0; funct7 = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_t", t, 32'd0);
      chk("reset_illegal", {31'b0, illegal}, 32'd0);
      rst = 1'b0;

      add_vec("sub",        1, 0, 3'd0, 7'h20, 32'd5,          32'd7,          32'hFFFF_FFFE, 0);
      add_vec("srai",       0, 1, 3'd5, 7'h20, 32'h8000_0000,  32'h0000_0404,  32'hF800_0000, 0);
      add_vec("srli",       0, 1, 3'd5, 7'h00, 32'h8000_0000,  32'h0000_0404,  32'h0800_0000, 0);
      add_vec("addi_f7",    0, 1, 3'd0, 7'h7F, 32'd1,          32'd2,          32'd3,         0);
      add_vec("add_wrap",   1, 0, 3'd0, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd0,         0);
      add_vec("slt",        1, 0, 3'd2, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd1,         0);
      add_vec("sltu",       1, 0, 3'd3, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd0,         0);
      add_vec("sll_upper",  1, 0, 3'd1, 7'h00, 32'd1,          32'hFFFF_FFE1,  32'd2,         0);
      add_vec("xor",        1, 0, 3'd4, 7'h00, 32'h00FF_00FF,  32'h0F0F_0F0F,  32'h0FF0_0FF0, 0);
      add_vec("or",         0, 1, 3'd6, 7'h00, 32'h00FF_0000,  32'h0000_0F0F,  32'h00FF_0F0F, 0);
      add_vec("and",        1, 0, 3'd7, 7'h00, 32'h00FF_00FF,  32'h0F0F_0F0F,  32'h000F_000F, 0);
      add_vec("sll_f7_ill", 1, 0, 3'd1, 7'h20, 32'd1,          32'd1,          32'd0,         1);
      add_vec("srli_f7_ill",0, 1, 3'd5, 7'h01, 32'hF0,         32'd4,          32'd0,         1);
      add_vec("no_op_ill",  0, 0, 3'd0, 7'h00, 32'd1,          32'd1,          32'd0,         1);
      add_vec("mulh",       1, 0, 3'd1, 7'h01, 32'hFFFF_FFFF,  32'd2,          MDU ? 32'hFFFF_FFFF : 32'd0, !MDU);
      add_vec("mulhu",      1, 0, 3'd3, 7'h01, 32'hFFFF_FFFF,  32'd2,          MDU ? 32'h0000_0001 : 32'd0, !MDU);
      add_vec("mulhsu",     1, 0, 3'd2, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  MDU ? 32'hFFFF_FFFF : 32'd0, !MDU);
      add_vec("mul",        1, 0, 3'd0, 7'h01, 32'd7,          32'hFFFF_FFFD,  MDU ? 32'hFFFF_FFEB : 32'd0, !MDU);
      add_vec("div_ovf",    1, 0, 3'd4, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF,  MDU ? 32'h8000_0000 : 32'd0, !MDU);
      add_vec("rem_ovf",    1, 0, 3'd6, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0, !MDU);
      add_vec("divu_zero",  1, 0, 3'd5, 7'h01, 32'd9,          32'd0,          MDU ? 32'hFFFF_FFFF : 32'd0, !MDU);
      add_vec("div_zero",   1, 0, 3'd4, 7'h01, 32'hFFFF_FFFB,  32'd0,          MDU ? 32'hFFFF_FFFF : 32'd0, !MDU);
      add_vec("rem_zero",   1, 0, 3'd6, 7'h01, 32'hFFFF_FFFB,  32'd0,          MDU ? 32'hFFFF_FFFB : 32'd0, !MDU);
      add_vec("rem_neg",    1, 0, 3'd6, 7'h01, 32'hFFFF_FFF9,  32'd2,          MDU ? 32'hFFFF_FFFF : 32'd0, !MDU);
      add_vec("div_neg",    1, 0, 3'd4, 7'h01, 32'hFFFF_FFF9,  32'd2,          MDU ? 32'hFFFF_FFFD : 32'd0, !MDU);

      foreach (vecs[i]) begin
         lat = (vecs[i].o && vecs[i].f7 == 7'h01 && MDU) ? XLEN + 1 : 1;
         run_op(vecs[i].name, vecs[i].o, vecs[i].oi, vecs[i].f3, vecs[i].f7,
                vecs[i].av, vecs[i].bv, vecs[i].et, vecs[i].ei, lat);
      end

      // Back-pressure: result held for 5 cycles while a new op waits on in_valid
      @(negedge clk);
      op = 1'b1; op_imm = 1'b0; funct3 = 3'd4; funct7 = 7'h00;
      a = 32'h0000_1234; b = 32'h0000_FF00; in_valid = 1'b1;
      @(posedge clk);
      #1;
      funct3 = 3'd0; a = 32'd10; b = 32'd20;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_t", t, 32'h0000_ED34);
         chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("release_in_ready", {31'b0, in_ready}, 32'd1);
      chk("release_out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("next_out_valid", {31'b0, out_valid}, 32'd1);
      chk("next_t", t, 32'd30);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Asynchronous reset while an operation is in flight
      @(negedge clk);
`ifdef MIMA_ALU_MDU_EN
      op = 1'b1; op_imm = 1'b0; funct3 = 3'd4; funct7 = 7'h01;
      a = 32'd1000; b = 32'd7; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy_out_valid", {31'b0, out_valid}, 32'd0);
      chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
`else
      op = 1'b1; op_imm = 1'b0; funct3 = 3'd0; funct7 = 7'h00;
      a = 32'd1; b = 32'd2; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_t", t, 32'd3);
`endif
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_t", t, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_discard", {31'b0, out_valid}, 32'd0);
      run_op("add_f7_ill", 1, 0, 3'd0, 7'h03, 32'd5, 32'd6, 32'd0, 1, 1);

      // Random operations against the reference model
      for (int r = 0; r < 150; r++) begin
         case ($urandom_range(0, 9))
            0:               begin o = 1'b0; oi = 1'b0; end
            1, 2, 3, 4:      begin o = 1'b1; oi = 1'b0; end
            default:         begin o = 1'b0; oi = 1'b1; end
         endcase
         case ($urandom_range(0, 7))
            0, 1, 2: f7 = 7'h00;
            3, 4:    f7 = 7'h20;
            5, 6:    f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         f3 = 3'($urandom);
         av = pick32();
         bv = pick32();
         model(o, oi, f3, f7, av, bv, et, ei, lat);
         run_op("rand", o, oi, f3, f7, av, bv, et, ei, lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
